// File: rtl/oh_dispatch4.sv
// 1-to-4 round-robin dispatcher: one valid/ready input stream fanned out to four
// one-entry lane registers, visiting enabled lanes strictly in pointer order.
module oh_dispatch4 #(
  parameter int DW   = 32,
  parameter     PROP = "DEFAULT"
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [3:0]      en,
  input  logic            in_valid,
  input  logic [DW-1:0]   in_data,
  output logic            in_ready,
  output logic [3:0]      out_valid,
  output logic [4*DW-1:0] out_data,
  input  logic [3:0]      out_ready,
  output logic [1:0]      ptr,
  output logic            idle
);

  logic [3:0]      valid_q, valid_d;
  logic [4*DW-1:0] data_q, data_d;
  logic [1:0]      ptr_q, ptr_d;

  logic [1:0] tgt;
  logic       has_tgt;
  logic [1:0] idx;
  logic       accept;

  // Scan from the far end back toward ptr so the nearest enabled lane wins.
  always_comb begin
    tgt     = ptr_q;
    has_tgt = 1'b0;
    idx     = '0;
    for (int unsigned k = 4; k > 0; k--) begin
      idx = ptr_q + 2'(k - 1);
      if (en[idx]) begin
        tgt     = idx;
        has_tgt = 1'b1;
      end
    end
  end

  assign in_ready = has_tgt & (~valid_q[tgt] | out_ready[tgt]);
  assign accept   = in_valid & in_ready;

  always_comb begin
    valid_d = valid_q & ~out_ready;
    data_d  = data_q;
    ptr_d   = ptr_q;
    if (accept) begin
      valid_d[tgt]         = 1'b1;
      data_d[tgt*DW +: DW] = in_data;
      ptr_d                = tgt + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      data_q  <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign ptr       = ptr_q;
  assign idle      = ~(valid_q[0] | valid_q[1] | valid_q[2] | valid_q[3]);

endmodule

// File: tb/tb_oh_dispatch4.sv
// Scoreboard bench for oh_dispatch4: a behavioural round-robin model predicts
// in_ready/ptr/out_valid, and per-lane queues hold the words each lane must emit.
module tb_oh_dispatch4;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [3:0]      en = '0;
  logic            in_valid = 1'b0;
  logic [DW-1:0]   in_data = '0;
  logic            in_ready;
  logic [3:0]      out_valid;
  logic [4*DW-1:0] out_data;
  logic [3:0]      out_ready = '0;
  logic [1:0]      ptr;
  logic            idle;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] sb [4][$];
  logic [3:0]    m_valid = '0;
  logic [1:0]    m_ptr = '0;

  oh_dispatch4 #(.DW(DW), .PROP("DEFAULT")) dut (
    .clk(clk), .reset(reset), .en(en), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .ptr(ptr), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_model();
    m_valid = '0;
    m_ptr   = '0;
    for (int i = 0; i < 4; i++) sb[i].delete();
  endtask

  // Inputs must already be driven; checks comb outputs, clocks once, checks state.
  task automatic cycle();
    logic [1:0]    t;
    logic          found;
    logic          exp_rdy;
    logic          acc;
    logic [DW-1:0] want;
    #1;
    found = 1'b0;
    t     = '0;
    for (int k = 0; k < 4; k++) begin
      if (!found && en[(m_ptr + k) % 4]) begin
        t     = 2'((m_ptr + k) % 4);
        found = 1'b1;
      end
    end
    exp_rdy = found && (!m_valid[t] || out_ready[t]);
    chk("in_ready", in_ready, exp_rdy);
    chk("idle", idle, m_valid == 4'b0000);
    for (int i = 0; i < 4; i++) begin
      if (m_valid[i] && out_ready[i]) begin
        if (sb[i].size() > 0) begin
          want = sb[i].pop_front();
          chk($sformatf("lane%0d_data", i), out_data[i*DW +: DW], want);
        end else begin
          chk($sformatf("lane%0d_sb_empty", i), 1, 0);
        end
      end
    end
    acc = in_valid && exp_rdy;
    if (acc) sb[t].push_back(in_data);
    @(posedge clk);
    #1;
    m_valid = m_valid & ~out_ready;
    if (acc) begin
      m_valid[t] = 1'b1;
      m_ptr      = t + 2'd1;
    end
    chk("out_valid", out_valid, m_valid);
    chk("ptr", ptr, m_ptr);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ptr", ptr, 0);
    chk("rst_idle", idle, 1);
    for (int i = 0; i < 4; i++) chk($sformatf("rst_data%0d", i), out_data[i*DW +: DW], 0);
    clear_model();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    do_reset();

    // Full enable, all lanes ready: A0..A3 spread over lanes 0..3.
    en = 4'b1111; out_ready = 4'b1111; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 32'hA0 + i;
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    chk("t1_ptr_wrap", ptr, 0);

    // Sparse enable: only lanes 1 and 3 receive words.
    en = 4'b1010; in_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      in_data = i;
      cycle();
    end
    in_valid = 1'b0;
    cycle();

    // Back-pressure: fill all lanes, then drain lane0 while reloading it.
    do_reset();
    en = 4'b1111; out_ready = 4'b0000; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 32'h10 + i;
      cycle();
    end
    in_data = 32'h14;
    cycle();
    chk("t3_blocked_ready", in_ready, 0);
    chk("t3_ptr", ptr, 0);
    chk("t3_idle", idle, 0);
    out_ready = 4'b0001;
    cycle();
    chk("t3_lane0_kept", out_valid[0], 1);
    chk("t3_lane0_new", out_data[0 +: DW], 32'h14);
    in_valid = 1'b0; out_ready = 4'b1111;
    cycle();
    cycle();

    // No enabled lane: nothing accepted; then a single lane.
    en = 4'b0000; in_valid = 1'b1; in_data = 32'h55; out_ready = 4'b0000;
    cycle();
    chk("t4_no_en_ready", in_ready, 0);
    en = 4'b0100; in_data = 32'h66;
    cycle();
    chk("t4_ptr", ptr, 3);
    chk("t4_lane2_data", out_data[2*DW +: DW], 32'h66);
    in_valid = 1'b0; out_ready = 4'b1111;
    cycle();

    // Asynchronous reset with lanes 1,2 occupied and ptr=2.
    do_reset();
    out_ready = 4'b0000; in_valid = 1'b1;
    en = 4'b0100; in_data = 32'h77;
    cycle();
    en = 4'b0010; in_data = 32'h88;
    cycle();
    in_valid = 1'b0;
    chk("t5_pre_valid", out_valid, 4'b0110);
    chk("t5_pre_ptr", ptr, 2);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_async_valid", out_valid, 0);
    chk("t5_async_ptr", ptr, 0);
    chk("t5_async_idle", idle, 1);
    clear_model();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    en = 4'b1111; out_ready = 4'b1111; in_valid = 1'b1; in_data = 32'h99;
    cycle();
    in_valid = 1'b0;
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
